// File: rtl/ntt_defines_pkg.sv
// Shared constants and types for the masked NTT add/sub butterfly front end.
package ntt_defines_pkg;

    localparam int unsigned MLKEM_Q     = 3329;
    localparam int unsigned ADDER_LAT   = 1;
    localparam int unsigned BARRETT_LAT = 6;
    localparam int unsigned RND_N       = 4;
    localparam int unsigned RND_W       = 14;

    typedef enum logic [1:0] {
        ADD    = 2'd0,
        SUB    = 2'd1,
        PASS_U = 2'd2
    } mode_e;

    // The unused encoding 2'b11 behaves as ADD.
    function automatic mode_e decode_mode(input logic [1:0] m);
        return (m == 2'd3) ? ADD : mode_e'(m);
    endfunction

endpackage

// File: rtl/ntt_masked_bfu_add_sub_multi_if.sv
// Operand/result bundle of the masked add/sub block; master drives operands, slave returns results.
interface ntt_masked_bfu_add_sub_multi_if
    import ntt_defines_pkg::*;
#(
    parameter int unsigned WIDTH     = 24,
    parameter int unsigned NUM_LANES = 4
);
    logic                                        zeroize;
    logic                                        in_valid;
    logic                                        in_last;
    logic [NUM_LANES-1:0][1:0]                   mode;
    logic [NUM_LANES-1:0][1:0][WIDTH-1:0]        u;
    logic [NUM_LANES-1:0][1:0][WIDTH-1:0]        v;
    logic [NUM_LANES-1:0][RND_N-1:0][RND_W-1:0]  rnd;
    logic [NUM_LANES-1:0][WIDTH-1:0]             rnd_24bit;
    logic [NUM_LANES-1:0][1:0][WIDTH-1:0]        res;
    logic                                        res_valid;
    logic                                        res_last;
    logic                                        busy;
    logic                                        block_done;

    modport master (
        output zeroize, in_valid, in_last, mode, u, v, rnd, rnd_24bit,
        input  res, res_valid, res_last, busy, block_done
    );

    modport slave (
        input  zeroize, in_valid, in_last, mode, u, v, rnd, rnd_24bit,
        output res, res_valid, res_last, busy, block_done
    );

endinterface

// File: rtl/abr_masked_N_bit_Arith_adder.sv
// One-cycle share-wise arithmetic adder; a fresh mask is added to one share and removed from the other.
module abr_masked_N_bit_Arith_adder #(
    parameter int unsigned WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [1:0][WIDTH-1:0] a,
    input  logic [1:0][WIDTH-1:0] b,
    input  logic [WIDTH-1:0]      mask,
    output logic [1:0][WIDTH-1:0] sum
);

    always_ff @(posedge clk) begin
        if (clr) begin
            sum <= '0;
        end else begin
            sum[0] <= a[0] + b[0] + mask;
            sum[1] <= a[1] + b[1] - mask;
        end
    end

endmodule

// File: rtl/masked_barrett_reduction.sv
// Six-stage Barrett reduction of a two-share value mod Q; shares are refreshed on entry and
// re-split with fresh randomness on exit, the quotient estimate works on the recombined value.
module masked_barrett_reduction
    import ntt_defines_pkg::*;
#(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned Q     = MLKEM_Q
) (
    input  logic                        clk,
    input  logic                        clr,
    input  logic [1:0][WIDTH-1:0]       x,
    input  logic [RND_N-1:0][RND_W-1:0] rnd,
    output logic [1:0][WIDTH-1:0]       y
);

    localparam int unsigned QW   = $clog2(Q);
    localparam int unsigned K    = WIDTH + QW;
    localparam int unsigned MUW  = WIDTH + 1;
    localparam int unsigned PW   = WIDTH + MUW;
    localparam logic [63:0] MU64 = (64'd1 << K) / 64'(Q);
    localparam logic [MUW-1:0] MU = MUW'(MU64);

    logic [2*RND_W-1:0]    pair_a, pair_b;
    logic [WIDTH-1:0]      mask_a, mask_b;
    logic [1:0][WIDTH-1:0] s1;
    logic [WIDTH-1:0]      xs2, xs3, xs4, qe4, r5, red;
    logic [PW-1:0]         prod3;
    logic [WIDTH-1:0]      mk1, mk2, mk3, mk4, mk5;

    assign pair_a = rnd[1:0];
    assign pair_b = rnd[3:2];

    // Fold the 28 random bits of each pair onto WIDTH mask bits so no randomness is dropped.
    always_comb begin
        mask_a = '0;
        mask_b = '0;
        for (int b = 0; b < 2 * RND_W; b++) begin
            mask_a[b % WIDTH] = mask_a[b % WIDTH] ^ pair_a[b];
            mask_b[b % WIDTH] = mask_b[b % WIDTH] ^ pair_b[b];
        end
    end

    // With K >= WIDTH the estimate undershoots floor(x/Q) by at most one, so r5 < 2Q.
    assign red = (r5 >= WIDTH'(Q)) ? (r5 - WIDTH'(Q)) : r5;

    always_ff @(posedge clk) begin
        if (clr) begin
            s1    <= '0;
            xs2   <= '0;
            xs3   <= '0;
            xs4   <= '0;
            prod3 <= '0;
            qe4   <= '0;
            r5    <= '0;
            mk1   <= '0;
            mk2   <= '0;
            mk3   <= '0;
            mk4   <= '0;
            mk5   <= '0;
            y     <= '0;
        end else begin
            s1[0] <= x[0] + mask_a;
            s1[1] <= x[1] - mask_a;
            mk1   <= mask_b;

            xs2   <= s1[0] + s1[1];
            mk2   <= mk1;

            prod3 <= PW'(xs2) * PW'(MU);
            xs3   <= xs2;
            mk3   <= mk2;

            qe4   <= WIDTH'(prod3 >> K);
            xs4   <= xs3;
            mk4   <= mk3;

            r5    <= xs4 - qe4 * WIDTH'(Q);
            mk5   <= mk4;

            y[0]  <= red - mk5;
            y[1]  <= mk5;
        end
    end

endmodule

// File: rtl/ntt_masked_add_sub_lane.sv
// One masked add/sub lane: share-wise negation of v for SUB, masked add, masked Barrett reduction.
module ntt_masked_add_sub_lane
    import ntt_defines_pkg::*;
#(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned Q     = MLKEM_Q
) (
    input  logic                        clk,
    input  logic                        clr,
    input  logic [1:0]                  mode,
    input  logic [1:0][WIDTH-1:0]       u,
    input  logic [1:0][WIDTH-1:0]       v,
    input  logic [RND_N-1:0][RND_W-1:0] rnd,
    input  logic [WIDTH-1:0]            rnd_24bit,
    output logic [1:0][WIDTH-1:0]       res
);

    logic [1:0][WIDTH-1:0]        vi;
    logic [1:0][WIDTH-1:0]        sum;
    logic [RND_N-1:0][RND_W-1:0]  rnd_q;

    // SUB turns v into shares of Q - v so u + vi stays non-negative before reduction.
    always_comb begin
        vi = '0;
        unique case (decode_mode(mode))
            ADD: vi = v;
            SUB: begin
                vi[0] = WIDTH'(Q) - v[0];
                vi[1] = ~v[1] + WIDTH'(1);
            end
            PASS_U: vi = '0;
            default: vi = v;
        endcase
    end

    abr_masked_N_bit_Arith_adder #(
        .WIDTH(WIDTH)
    ) u_add (
        .clk (clk),
        .clr (clr),
        .a   (u),
        .b   (vi),
        .mask(rnd_24bit),
        .sum (sum)
    );

    // Barrett randomness travels one stage to stay with its operand.
    always_ff @(posedge clk) begin
        if (clr) begin
            rnd_q <= '0;
        end else begin
            rnd_q <= rnd;
        end
    end

    masked_barrett_reduction #(
        .WIDTH(WIDTH),
        .Q    (Q)
    ) u_barrett (
        .clk(clk),
        .clr(clr),
        .x  (sum),
        .rnd(rnd_q),
        .y  (res)
    );

endmodule

// File: rtl/ntt_masked_bfu_add_sub_multi.sv
// Multi-lane masked NTT add/sub: per-lane datapaths plus shared valid/last pipe and in-flight counter.
// Define NTT_BFU_ADD_SUB_INPUT_FLOP_EN to register all operands on entry (latency 7 -> 8).
module ntt_masked_bfu_add_sub_multi
    import ntt_defines_pkg::*;
#(
    parameter int unsigned WIDTH     = 24,
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned Q         = MLKEM_Q
) (
    input logic                           clk,
    input logic                           reset,
    ntt_masked_bfu_add_sub_multi_if.slave bus
);

`ifdef NTT_BFU_ADD_SUB_INPUT_FLOP_EN
    localparam int unsigned IN_LAT = 1;
`else
    localparam int unsigned IN_LAT = 0;
`endif
    localparam int unsigned LAT = IN_LAT + ADDER_LAT + BARRETT_LAT;
    localparam int unsigned CW  = $clog2(LAT + 1);

    logic                                       clr;
    logic [NUM_LANES-1:0][1:0]                  mode_s;
    logic [NUM_LANES-1:0][1:0][WIDTH-1:0]       u_s, v_s, res_w;
    logic [NUM_LANES-1:0][RND_N-1:0][RND_W-1:0] rnd_s;
    logic [NUM_LANES-1:0][WIDTH-1:0]            rnd24_s;
    logic [LAT-1:0]                             valid_pipe, last_pipe;
    logic [CW-1:0]                              cnt, cnt_nxt;
    logic                                       busy_q, done_q;

    // Zeroize and reset clear the same state; both win over a same-cycle operand.
    assign clr = reset | bus.zeroize;

`ifdef NTT_BFU_ADD_SUB_INPUT_FLOP_EN
    always_ff @(posedge clk) begin
        if (clr) begin
            mode_s  <= '0;
            u_s     <= '0;
            v_s     <= '0;
            rnd_s   <= '0;
            rnd24_s <= '0;
        end else begin
            mode_s  <= bus.mode;
            u_s     <= bus.u;
            v_s     <= bus.v;
            rnd_s   <= bus.rnd;
            rnd24_s <= bus.rnd_24bit;
        end
    end
`else
    assign mode_s  = bus.mode;
    assign u_s     = bus.u;
    assign v_s     = bus.v;
    assign rnd_s   = bus.rnd;
    assign rnd24_s = bus.rnd_24bit;
`endif

    for (genvar i = 0; i < NUM_LANES; i++) begin : gen_lane
        ntt_masked_add_sub_lane #(
            .WIDTH(WIDTH),
            .Q    (Q)
        ) u_lane (
            .clk      (clk),
            .clr      (clr),
            .mode     (mode_s[i]),
            .u        (u_s[i]),
            .v        (v_s[i]),
            .rnd      (rnd_s[i]),
            .rnd_24bit(rnd24_s[i]),
            .res      (res_w[i])
        );
    end

    // In-flight count: up on accept, down on result, saturating at LAT.
    always_comb begin
        cnt_nxt = cnt;
        if (bus.in_valid && !valid_pipe[LAT-1]) begin
            if (cnt != CW'(LAT)) cnt_nxt = cnt + CW'(1);
        end else if (!bus.in_valid && valid_pipe[LAT-1]) begin
            if (cnt != '0) cnt_nxt = cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            valid_pipe <= '0;
            last_pipe  <= '0;
            cnt        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            valid_pipe <= {valid_pipe[LAT-2:0], bus.in_valid};
            last_pipe  <= {last_pipe[LAT-2:0], bus.in_valid & bus.in_last};
            cnt        <= cnt_nxt;
            busy_q     <= (cnt_nxt != '0);
            done_q     <= valid_pipe[LAT-2] & last_pipe[LAT-2];
        end
    end

    assign bus.res        = res_w;
    assign bus.res_valid  = valid_pipe[LAT-1];
    assign bus.res_last   = last_pipe[LAT-1];
    assign bus.busy       = busy_q;
    assign bus.block_done = done_q;

endmodule

// File: tb/tb_ntt_masked_bfu_add_sub_multi.sv
// Directed + random bench for ntt_masked_bfu_add_sub_multi against a modular-arithmetic model.
module tb_ntt_masked_bfu_add_sub_multi;
    import ntt_defines_pkg::*;

    localparam int unsigned WIDTH = 24;
    localparam int unsigned NL    = 4;
    localparam int unsigned QV    = MLKEM_Q;
`ifdef NTT_BFU_ADD_SUB_INPUT_FLOP_EN
    localparam int LAT = 8;
`else
    localparam int LAT = 7;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ntt_masked_bfu_add_sub_multi_if #(.WIDTH(WIDTH), .NUM_LANES(NL)) bus ();

    ntt_masked_bfu_add_sub_multi #(
        .WIDTH    (WIDTH),
        .NUM_LANES(NL),
        .Q        (QV)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic                valid;
        logic                last;
        logic [NL-1:0][31:0] want;
    } ent_t;

    ent_t hist[$];
    ent_t cur;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_rv  = 0;
    int   n_bd  = 0;
    int   max_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        assert (obs === want)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
        end
    endtask

    function automatic int unsigned pick();
        int unsigned sel;
        sel = $urandom_range(0, 5);
        if (sel == 0) return 0;
        if (sel == 1) return QV - 1;
        return $urandom_range(0, QV - 1);
    endfunction

    // Split u and v into random arithmetic shares and record the expected reduced result.
    task automatic set_lane(input int i, input logic [1:0] m, input int unsigned uv, input int unsigned vv);
        logic [WIDTH-1:0] r, s;
        r = WIDTH'($urandom);
        s = WIDTH'($urandom);
        bus.mode[i] = m;
        bus.u[i][0] = WIDTH'(uv) - r;
        bus.u[i][1] = r;
        bus.v[i][0] = WIDTH'(vv) - s;
        bus.v[i][1] = s;
        case (m)
            2'd1:    cur.want[i] = (uv + QV - vv) % QV;
            2'd2:    cur.want[i] = uv;
            default: cur.want[i] = (uv + vv) % QV;
        endcase
    endtask

    task automatic rand_lanes();
        for (int i = 0; i < NL; i++) set_lane(i, 2'($urandom_range(0, 3)), pick(), pick());
    endtask

    task automatic flush_model();
        hist.delete();
        for (int k = 0; k < LAT - 1; k++) hist.push_back('0);
    endtask

    // One clock: fresh randomness, advance the model, compare every output 1 ns after the edge.
    task automatic step();
        logic             clr_now;
        ent_t             e;
        int               win;
        logic [WIDTH-1:0] rec;
        for (int i = 0; i < NL; i++) begin
            for (int j = 0; j < RND_N; j++) bus.rnd[i][j] = RND_W'($urandom);
            bus.rnd_24bit[i] = WIDTH'($urandom);
        end
        cur.valid = bus.in_valid;
        cur.last  = bus.in_valid & bus.in_last;
        clr_now   = reset | bus.zeroize;
        @(posedge clk);
        #1;
        if (clr_now) begin
            flush_model();
            e = '0;
        end else begin
            hist.push_back(cur);
            e = hist.pop_front();
        end
        win = int'(e.valid);
        foreach (hist[k]) win += int'(hist[k].valid);
        chk("res_valid", 32'(bus.res_valid), 32'(e.valid));
        chk("res_last", 32'(bus.res_last), 32'(e.valid & e.last));
        chk("block_done", 32'(bus.block_done), 32'(e.valid & e.last));
        chk("busy", 32'(bus.busy), 32'(win != 0));
        chk("count", 32'(dut.cnt), 32'(win));
        if (e.valid) begin
            for (int i = 0; i < NL; i++) begin
                rec = bus.res[i][0] + bus.res[i][1];
                chk($sformatf("res_lane%0d", i), 32'(rec), e.want[i]);
            end
        end
        if (clr_now) begin
            for (int i = 0; i < NL; i++) begin
                chk($sformatf("clr_res0_lane%0d", i), 32'(bus.res[i][0]), 32'd0);
                chk($sformatf("clr_res1_lane%0d", i), 32'(bus.res[i][1]), 32'd0);
            end
        end
        n_rv += int'(bus.res_valid);
        n_bd += int'(bus.block_done);
        if (int'(dut.cnt) > max_cnt) max_cnt = int'(dut.cnt);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        reset        = 1'b1;
        bus.zeroize  = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        cur          = '0;
        rand_lanes();
        step();
        step();
        reset = 1'b0;

        // Lane 0 ADD 3000+1000 -> 671, lane 1 SUB 100-200 -> 3229, lane 2 PASS_U 3328, lane 3 mode 11.
        bus.in_valid = 1'b1;
        set_lane(0, 2'd0, 3000, 1000);
        set_lane(1, 2'd1, 100, 200);
        set_lane(2, 2'd2, 3328, pick());
        set_lane(3, 2'd3, pick(), pick());
        step();
        idle(LAT + 1);

        // 16-beat stream, last on the 16th.
        n_rv = 0;
        n_bd = 0;
        for (int k = 0; k < 16; k++) begin
            bus.in_valid = 1'b1;
            bus.in_last  = (k == 15);
            rand_lanes();
            step();
        end
        idle(LAT + 2);
        chk("stream_res_valid_count", 32'(n_rv), 32'd16);
        chk("stream_block_done_count", 32'(n_bd), 32'd1);

        // valid / bubble / valid
        max_cnt = 0;
        bus.in_valid = 1'b1;
        rand_lanes();
        step();
        idle(1);
        bus.in_valid = 1'b1;
        rand_lanes();
        step();
        idle(LAT + 2);
        chk("bubble_count_max", 32'(max_cnt), 32'd2);

        // Reset three cycles after an accepted operand.
        bus.in_valid = 1'b1;
        rand_lanes();
        step();
        idle(2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_rv = 0;
        idle(LAT + 2);
        chk("reset_drops_inflight", 32'(n_rv), 32'd0);

        // Zeroize with a full pipe and a new operand in the same cycle.
        for (int k = 0; k < LAT + 2; k++) begin
            bus.in_valid = 1'b1;
            rand_lanes();
            step();
        end
        bus.zeroize  = 1'b1;
        bus.in_valid = 1'b1;
        rand_lanes();
        step();
        bus.zeroize = 1'b0;
        n_rv = 0;
        idle(LAT + 2);
        chk("zeroize_drops_inflight", 32'(n_rv), 32'd0);

        // Random traffic with bubbles, boundary operands and scattered last markers.
        for (int k = 0; k < 80; k++) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_last  = bus.in_valid && ($urandom_range(0, 7) == 0);
            rand_lanes();
            step();
        end
        idle(LAT + 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ntt_masked_bfu_add_sub_multi.md
NTT_MASKED_BFU_ADD_SUB_MULTI -- requirements
Module: ntt_masked_bfu_add_sub_multi

Interface
REQ-001 The block SHALL have parameter WIDTH, default 24: bit width of one arithmetic share.
REQ-002 The block SHALL have parameter NUM_LANES, default 4: number of independent add/sub lanes.
REQ-003 The block SHALL have parameter Q, default MLKEM_Q (3329): reduction modulus.
REQ-004 The block SHALL have port clk, input, 1: the single clock.
REQ-005 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 The block SHALL have port zeroize, input, 1: synchronous clear of all state.
REQ-007 The block SHALL have port in_valid, input, 1: the operand set is valid this cycle.
REQ-008 The block SHALL have port in_last, input, 1: marks the last operand set of a block.
REQ-009 The block SHALL have port mode, input, [NUM_LANES][2]: per-lane operation (ADD, SUB, PASS_U).
REQ-010 The block SHALL have port u, input, [NUM_LANES][2][WIDTH]: two arithmetic shares of u per lane.
REQ-011 The block SHALL have port v, input, [NUM_LANES][2][WIDTH]: two arithmetic shares of v per lane.
REQ-012 The block SHALL have port rnd, input, [NUM_LANES][4][14]: fresh masking randomness per lane.
REQ-013 The block SHALL have port rnd_24bit, input, [NUM_LANES][WIDTH]: fresh randomness per lane.
REQ-014 The block SHALL have port res, output, [NUM_LANES][2][WIDTH]: reduced result shares per lane.
REQ-015 The block SHALL have port res_valid, output, 1: res holds a valid result this cycle.
REQ-016 The block SHALL have port res_last, output, 1: in_last delayed to line up with res_valid.
REQ-017 The block SHALL have port busy, output, 1: at least one operand set is in flight.
REQ-018 The block SHALL have port block_done, output, 1: one-cycle pulse when a last-marked result is output.

Function
REQ-019 The block SHALL define LAT = 7 (1 adder cycle + 6 Barrett cycles) from in_valid to res_valid, or 8 with the macro in REQ-034.
REQ-020 The block SHALL compute ADD as vi0=v0, vi1=v1 and SUB as vi0=Q-v0, vi1=(~v1+1) mod 2^WIDTH, then feed u+vi through the masked adder and masked Barrett reduction.
REQ-021 For every lane and mode, the recombined result (res0+res1) mod 2^WIDTH SHALL be in [0,Q) and equal (u±v) mod Q.
REQ-022 In PASS_U mode the block SHALL output Barrett(u+0), keeping latency identical to the other modes.
REQ-023 The block SHALL treat mode 2'b11 as ADD.
REQ-024 The block SHALL sample mode per lane together with its operands; a mode change on consecutive cycles SHALL affect only the corresponding results.
REQ-025 The block SHALL provide no backpressure: it accepts one operand set every cycle, and in_valid=0 inserts a bubble (res_valid=0 LAT cycles later).
REQ-026 The block SHALL keep a LAT-deep shift register of {valid,last}; res_valid and res_last SHALL be its output stage.
REQ-027 The block SHALL hold an in-flight counter (width clog2(LAT+1)): +1 on in_valid, -1 on res_valid, unchanged when both occur; busy = (count != 0); the counter SHALL saturate at LAT.
REQ-028 The block SHALL assert block_done = res_valid & res_last for exactly one cycle.
REQ-029 When res_valid=0, res SHALL be don't-care; the bench SHALL NOT check it.
REQ-030 Zeroize SHALL, on the next clock edge, clear every data register, the valid/last pipeline and the counter; operands accepted in the same cycle as zeroize SHALL be discarded.

Reset
REQ-031 Reset SHALL give res=0, res_valid=0, res_last=0, busy=0, block_done=0, counter=0.
REQ-032 Reset asserted mid-operation SHALL drop all in-flight results; no res_valid SHALL follow for them.
REQ-033 Reset SHALL take priority over in_valid in the same cycle.

Configuration
REQ-034 With macro NTT_BFU_ADD_SUB_INPUT_FLOP_EN defined, the block SHALL register u, v, mode, rnd, in_valid and in_last before the SUB negation, giving LAT=8; when the macro is undefined, the inputs SHALL be combinational and LAT=7.

Structure
REQ-035 ntt_defines_pkg SHALL contain the mode enum (ADD=0, SUB=1, PASS_U=2) and the latency constants for the adder and for the Barrett reduction.
REQ-036 One sub-module ntt_masked_add_sub_lane SHALL hold the per-lane negation, abr_masked_N_bit_Arith_adder and masked_barrett_reduction, with one instance per lane.
REQ-037 The valid/last pipeline and the counter SHALL be shared at the top level.

Verification
REQ-038 The bench SHALL cover lane 0 ADD, u=(3000-r,r), v=(1000-s,s) -> recombined res=671 after LAT cycles, with res_valid asserted.
REQ-039 The bench SHALL cover lane 1 SUB, u=100, v=200 (masked) -> res=3229; lane 2 PASS_U, u=3328 -> res=3328, in the same cycle.
REQ-040 The bench SHALL cover a 16-cycle back-to-back stream with in_last on the 16th and random modes -> 16 consecutive res_valid, block_done only on the 16th, busy=0 one cycle later.
REQ-041 The bench SHALL cover a valid/bubble/valid pattern -> res_valid pattern 1,0,1 shifted by LAT, with the counter never above 2.
REQ-042 The bench SHALL cover reset asserted 3 cycles after in_valid -> no res_valid, busy=0 and res=0 on the next cycle.
REQ-043 The bench SHALL cover zeroize during a full pipeline with in_valid=1 -> all outputs 0 on the next cycle and no res_valid afterwards.
